cmp_share_arbiter: RTL and testbench
====================================

Name: cmp_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one equality comparator instance (module comparator, enable-gated A==B) among NREQ requesters, e.g. branch unit, loop counter and DMA match logic. It latches the winning requester's operand pair, drives the comparator for one cycle and returns a registered result tagged with the requester ID. The block sits between the requesting functional units and the single comparator datapath.

Parameters:
width, 8, operand width passed to the comparator
NREQ, 4, number of requesters (2..8)
IDW, 2, requester ID width, clog2(NREQ)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  request per requester, level; held until matching gnt bit seen
a_bus  in  NREQ*width  operand A per requester; slice i = bits [i*width +: width]
b_bus  in  NREQ*width  operand B per requester, same slicing
gnt  out  NREQ  one-hot grant, one-cycle pulse; operands sampled in same cycle
busy  out  1  high from grant cycle until done cycle inclusive
done  out  1  one-cycle pulse, result valid
eq  out  1  A==B for granted pair, valid when done=1
gt  out  1  A>B unsigned, valid when done=1 (see optional feature)
rid  out  IDW  ID of requester owning current result, valid when done=1

Behaviour:
- Reset (async, rst_n=0): state=IDLE; gnt=0, busy=0, done=0, eq=0, gt=0, rid=0; operand latches=0; rr pointer=NREQ-1, so requester 0 has top priority first.
- All outputs are registered. Comparator En is driven high only in CMP state, so comparator output is 0 otherwise.
- FSM IDLE -> GRANT -> CMP -> RESP -> IDLE. No back-to-back overlap: one transaction per 4 cycles max.
- IDLE: if req != 0, select winner by round-robin. Search order is ptr+1, ptr+2, ... wrapping modulo NREQ. Latch winner's A, B and ID; go GRANT. If req == 0, stay.
- GRANT: gnt[winner]=1 for this cycle only; busy=1. The requester must deassert req on the cycle after it sees gnt. Operands were captured in IDLE, so later a_bus/b_bus changes are ignored.
- CMP: comparator fed from latches with En=1. Capture its out into eq.
- RESP: done=1, eq/rid/gt valid, busy=1; ptr <= winner. Next cycle returns to IDLE, busy=0, done=0. eq, gt and rid hold their values until the next RESP.
- Latency: req high in IDLE at cycle t -> gnt at t+1 -> done at t+3.
- A requester still holding req after done is eligible again, but with the lowest priority.
- A req that drops before its grant is dropped silently; no state change.
- Simultaneous requests: exactly one winner; the others wait. Starvation bound is NREQ transactions.
- A req bit for an index >= NREQ does not exist; width is fixed by the parameter.
- rst_n asserted mid-transaction aborts immediately. No done is issued, the pointer resets and the pending requester must re-request.
- Widths: operand compare is unsigned, full width, no truncation.

Optional Feature:
CMP_SHARE_GT_EN
- Defined: gt = (A_latched > B_latched), registered in CMP alongside eq and valid at done.
- Undefined: no magnitude logic is synthesized; gt is tied 0. Port list is unchanged in both builds.

Decomposition:
- Package cmp_share_pkg holds: FSM state typedef (IDLE, GRANT, CMP, RESP, 2-bit encoding) and default constants for NREQ and width.
- Sub-module rr_pick is natural: purely combinational. Inputs are req and ptr; outputs are one-hot winner and winner ID.
- The existing comparator is instantiated once, unmodified, with parameter width passed through.

Test Plan:
- Reset then single req=4'b0001, A0=8'h5A, B0=8'h5A -> gnt=0001 one cycle later; done 2 cycles after gnt with eq=1, rid=0.
- req=4'b0100, A2=8'h10, B2=8'h11 -> gnt=0100, done eq=0, rid=2. With CMP_SHARE_GT_EN, A2=8'hFF, B2=8'h01 -> gt=1.
- req=4'b1111 held continuously -> grant order 0,1,2,3,0. Each done is 4 cycles apart; rid matches the grant order.
- Requester 1 changes A1 from 8'h33 to 8'h00 the cycle after gnt, with B1=8'h33 -> eq=1, proving the operand latch.
- rst_n pulsed low during CMP -> all outputs 0 immediately; no done. After release, req=4'b0010 -> gnt=0010.
- Hold req=0 for 20 cycles after reset -> gnt, busy and done stay 0; the comparator En is never asserted.

Source files
------------

// File: rtl/cmp_share_arbiter_pkg.sv
// ============================================================================
//  Module      : cmp_share_pkg
//  Description : Shared types and default constants for the comparator-sharing
//                round-robin arbiter (FSM state encoding, default sizes).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmp_share_pkg;

    // Default configuration of the arbiter slice
    localparam int c_NREQ_DEF  = 4;
    localparam int c_WIDTH_DEF = 8;

    // Transaction sequencer states, one transaction per 4 cycles
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        CMP   = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage : cmp_share_pkg

`default_nettype wire

// File: rtl/cmp_share_arbiter_if.sv
// ============================================================================
//  Module      : cmp_share_arbiter_if
//  Description : Requester-side bus of the comparator-sharing arbiter.
//                master = functional units, slave = arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cmp_share_arbiter_if
    import cmp_share_pkg::*;
#(
    parameter int width = c_WIDTH_DEF,
    parameter int NREQ  = c_NREQ_DEF,
    parameter int IDW   = $clog2(NREQ)
);

    logic [NREQ-1:0]       req;
    logic [NREQ*width-1:0] a_bus;
    logic [NREQ*width-1:0] b_bus;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic                  eq;
    logic                  gt;
    logic [IDW-1:0]        rid;

    modport master (
        output req, a_bus, b_bus,
        input  gnt, busy, done, eq, gt, rid
    );

    modport slave (
        input  req, a_bus, b_bus,
        output gnt, busy, done, eq, gt, rid
    );

endinterface : cmp_share_arbiter_if

`default_nettype wire

// File: rtl/cmp_share_arbiter_rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Searches ptr+1, ptr+2, ...
//                modulo NREQ and returns the first set request as a one-hot
//                vector plus its index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  wire logic [NREQ-1:0] req,
    input  wire logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0]      win,
    output logic [IDW-1:0]       win_id,
    output logic                 any
);

    int             w_pos;
    logic [IDW-1:0] w_idx;

    // First requester after the pointer wins; the pointer itself is checked last
    always_comb begin
        win    = '0;
        win_id = '0;
        any    = 1'b0;
        w_pos  = 0;
        w_idx  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_pos = (int'(ptr) + i) % NREQ;
            w_idx = IDW'(w_pos);
            if (!any && req[w_idx]) begin
                any         = 1'b1;
                win[w_idx]  = 1'b1;
                win_id      = w_idx;
            end
        end
    end

endmodule : rr_pick

`default_nettype wire

// File: rtl/comparator.sv
// ============================================================================
//  Module      : comparator
//  Description : Enable-gated equality comparator; out is 0 while En is low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator #(
    parameter int width = 8
) (
    input  wire logic [width-1:0] A,
    input  wire logic [width-1:0] B,
    input  wire logic             En,
    output logic                  out
);

    assign out = En & (A == B);

endmodule : comparator

`default_nettype wire

// File: rtl/cmp_share_arbiter.sv
// ============================================================================
//  Module      : cmp_share_arbiter
//  Description : Round-robin arbiter sharing one equality comparator among
//                NREQ requesters. Latches the winner's operands, runs the
//                comparator for one cycle and returns a registered, tagged
//                result. Sequence IDLE -> GRANT -> CMP -> RESP.
//                Optional macro CMP_SHARE_GT_EN adds an unsigned A>B result
//                on gt; without it gt is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_share_arbiter
    import cmp_share_pkg::*;
#(
    parameter int width = c_WIDTH_DEF,
    parameter int NREQ  = c_NREQ_DEF,
    parameter int IDW   = $clog2(NREQ)
) (
    input wire logic           clk,
    input wire logic           rst_n,
    cmp_share_arbiter_if.slave bus
);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [width-1:0] r_a;
    logic [width-1:0] r_b;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_rid;
    logic [NREQ-1:0]  r_gnt;
    logic             r_busy;
    logic             r_done;
    logic             r_eq;

    logic [NREQ-1:0]  w_gnt_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_load;
    logic             w_cap;
    logic             w_ptr_upd;

    logic [NREQ-1:0]  w_win;
    logic [IDW-1:0]   w_win_id;
    logic             w_any;
    logic             w_cmp_en;
    logic             w_cmp_out;

    logic [width-1:0] w_a_arr [NREQ];
    logic [width-1:0] w_b_arr [NREQ];

    // Unpack the flat operand buses into per-requester slices
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_a_arr[i] = bus.a_bus[i*width +: width];
        assign w_b_arr[i] = bus.b_bus[i*width +: width];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (r_ptr),
        .win    (w_win),
        .win_id (w_win_id),
        .any    (w_any)
    );

    // The comparator only sees an enable in CMP, so its output is 0 elsewhere
    assign w_cmp_en = (r_state == CMP);

    comparator #(
        .width (width)
    ) u_cmp (
        .A   (r_a),
        .B   (r_b),
        .En  (w_cmp_en),
        .out (w_cmp_out)
    );

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_cap       = 1'b0;
        w_ptr_upd   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = w_win;
                    w_busy_nxt  = 1'b1;
                    w_load      = 1'b1;
                end
            end
            GRANT: begin
                w_state_nxt = CMP;
                w_busy_nxt  = 1'b1;
            end
            CMP: begin
                w_state_nxt = RESP;
                w_busy_nxt  = 1'b1;
                w_done_nxt  = 1'b1;
                w_cap       = 1'b1;
            end
            RESP: begin
                w_state_nxt = IDLE;
                w_ptr_upd   = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and handshake outputs; reset aborts any transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ptr   <= IDW'(NREQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            if (w_ptr_upd) begin
                r_ptr <= r_id;
            end
        end
    end

    // Operand latch at selection time and result capture out of CMP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_id  <= '0;
            r_eq  <= 1'b0;
            r_rid <= '0;
        end else begin
            if (w_load) begin
                r_a  <= w_a_arr[w_win_id];
                r_b  <= w_b_arr[w_win_id];
                r_id <= w_win_id;
            end
            if (w_cap) begin
                r_eq  <= w_cmp_out;
                r_rid <= r_id;
            end
        end
    end

`ifdef CMP_SHARE_GT_EN
    logic r_gt;

    // Unsigned magnitude result, captured together with eq
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gt <= 1'b0;
        end else if (w_cap) begin
            r_gt <= (r_a > r_b);
        end
    end

    assign bus.gt = r_gt;
`else
    assign bus.gt = 1'b0;
`endif

    assign bus.gnt  = r_gnt;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.eq   = r_eq;
    assign bus.rid  = r_rid;

endmodule : cmp_share_arbiter

`default_nettype wire

// File: tb/tb_cmp_share_arbiter.sv
// ============================================================================
//  Module      : tb_cmp_share_arbiter
//  Description : Directed self-checking bench for cmp_share_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmp_share_arbiter;

    localparam int c_W  = 8;
    localparam int c_N  = 4;
    localparam int c_IW = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cmp_share_arbiter_if #(.width(c_W), .NREQ(c_N), .IDW(c_IW)) bus ();

    cmp_share_arbiter #(
        .width (c_W),
        .NREQ  (c_N),
        .IDW   (c_IW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_gt(input logic [7:0] a, input logic [7:0] b);
`ifdef CMP_SHARE_GT_EN
        return a > b;
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
        bus.a_bus[idx*c_W +: c_W] = a;
        bus.b_bus[idx*c_W +: c_W] = b;
    endtask

    // One isolated transaction; optionally changes A the cycle after grant
    task automatic run_single(input string tag, input int idx, input logic [7:0] a,
                              input logic [7:0] b, input bit chg, input logic [7:0] a_new);
        @(negedge clk);
        set_ops(idx, a, b);
        bus.req = 4'(1 << idx);
        @(negedge clk);
        check({tag, "_gnt"},  32'(bus.gnt),  32'(1 << idx));
        check({tag, "_busy"}, 32'(bus.busy), 32'(1));
        bus.req = '0;
        if (chg) bus.a_bus[idx*c_W +: c_W] = a_new;
        @(negedge clk);
        check({tag, "_gnt_off"}, 32'(bus.gnt),  32'(0));
        check({tag, "_nodone"},  32'(bus.done), 32'(0));
        @(negedge clk);
        check({tag, "_done"}, 32'(bus.done), 32'(1));
        check({tag, "_eq"},   32'(bus.eq),   32'(a == b));
        check({tag, "_gt"},   32'(bus.gt),   32'(exp_gt(a, b)));
        check({tag, "_rid"},  32'(bus.rid),  32'(idx));
        @(negedge clk);
        check({tag, "_done_off"}, 32'(bus.done), 32'(0));
        check({tag, "_busy_off"}, 32'(bus.busy), 32'(0));
        check({tag, "_eq_hold"},  32'(bus.eq),   32'(a == b));
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.req   = '0;
        bus.a_bus = '0;
        bus.b_bus = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt",  32'(bus.gnt),  32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_eq",   32'(bus.eq),   32'(0));
        check("rst_gt",   32'(bus.gt),   32'(0));
        check("rst_rid",  32'(bus.rid),  32'(0));
        rst_n = 1'b1;

        // Idle period: nothing must move, comparator stays disabled
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_gnt",  32'(bus.gnt),        32'(0));
            check("idle_busy", 32'(bus.busy),       32'(0));
            check("idle_done", 32'(bus.done),       32'(0));
            check("idle_en",   32'(dut.u_cmp.En),   32'(0));
        end

        run_single("t1_eq",    0, 8'h5A, 8'h5A, 1'b0, 8'h00);
        run_single("t2_ne",    2, 8'h10, 8'h11, 1'b0, 8'h00);
        run_single("t2_gt",    2, 8'hFF, 8'h01, 1'b0, 8'h00);
        run_single("t4_latch", 1, 8'h33, 8'h33, 1'b1, 8'h00);

        // Fresh pointer, then all four requesters held high continuously
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < c_N; i++) begin
            set_ops(i, 8'(8'h40 + i), (i % 2 == 0) ? 8'(8'h40 + i) : 8'h00);
        end
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_gnt", 32'(bus.gnt), 32'(1 << (k % c_N)));
            @(negedge clk);
            @(negedge clk);
            check("rr_done", 32'(bus.done), 32'(1));
            check("rr_rid",  32'(bus.rid),  32'(k % c_N));
            check("rr_eq",   32'(bus.eq),   32'((k % 2) == 0));
            @(negedge clk);
            check("rr_gap_done", 32'(bus.done), 32'(0));
        end
        bus.req = '0;
        @(negedge clk);

        // Reset asserted during CMP aborts the transaction
        set_ops(1, 8'h21, 8'h21);
        bus.req = 4'b0010;
        @(negedge clk);
        check("ab_gnt", 32'(bus.gnt), 32'(4'b0010));
        bus.req = '0;
        @(negedge clk);
        check("ab_in_cmp", 32'(dut.u_cmp.En), 32'(1));
        rst_n = 1'b0;
        #1;
        check("ab_gnt0",  32'(bus.gnt),      32'(0));
        check("ab_busy0", 32'(bus.busy),     32'(0));
        check("ab_done0", 32'(bus.done),     32'(0));
        check("ab_eq0",   32'(bus.eq),       32'(0));
        check("ab_en0",   32'(dut.u_cmp.En), 32'(0));
        @(negedge clk);
        check("ab_nodone", 32'(bus.done), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("ab_nodone2", 32'(bus.done), 32'(0));
        run_single("ab_rereq", 1, 8'h77, 8'h76, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_cmp_share_arbiter

`default_nettype wire
